// File: rtl/bnn_param_loader_pkg.sv
// bnn_param_loader_pkg: chain geometry, FSM encoding and byte-chunk helper shared by the loader and bench
package bnn_param_loader_pkg;
    localparam int NEURONS    = 8;
    localparam int INPUTS     = 8;
    localparam int BIAS_BITS  = 3;
    localparam int CHAIN_BITS = NEURONS * (INPUTS + BIAS_BITS);
    localparam int NBYTES     = (CHAIN_BITS + 7) / 8;
    localparam int CNT_W      = $clog2(CHAIN_BITS + 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        VERIFY = 2'd2
    } state_e;

    // Number of bits of the next byte that still belong to the chain (last byte may be partial)
    function automatic logic [3:0] chunk_len(input logic [CNT_W-1:0] cnt);
        logic [CNT_W-1:0] rem;
        rem = CNT_W'(CHAIN_BITS) - cnt;
        return (rem >= CNT_W'(8)) ? 4'd8 : rem[3:0];
    endfunction
endpackage

// File: rtl/bnn_param_serializer.sv
// bnn_param_serializer: byte fetch and MSB-first bit shifter feeding the neuron chain
module bnn_param_serializer
    import bnn_param_loader_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             active,
    input  logic             clear,
    input  logic [CNT_W-1:0] bit_cnt,
    input  logic [7:0]       in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             setup,
    output logic             msb
);
    logic [7:0] shreg_q, shreg_d;
    logic [3:0] bits_left_q, bits_left_d;
    logic       accept;

    assign in_ready = active && bits_left_q == 4'd0 && bit_cnt < CNT_W'(CHAIN_BITS);
    assign setup    = active && bits_left_q != 4'd0;
    assign msb      = shreg_q[7];
    assign accept   = in_ready && in_valid;

    // Load a fresh byte when empty, otherwise shift one bit out per setup cycle
    always_comb begin
        shreg_d     = accept ? in_data : setup ? {shreg_q[6:0], 1'b0} : shreg_q;
        bits_left_d = clear ? 4'd0 : accept ? chunk_len(bit_cnt) : setup ? bits_left_q - 4'd1 : bits_left_q;
    end

    // Shifter state registers
    always_ff @(posedge clk) begin
        if (reset) begin
            shreg_q     <= '0;
            bits_left_q <= '0;
        end else begin
            shreg_q     <= shreg_d;
            bits_left_q <= bits_left_d;
        end
    end
endmodule

// File: rtl/bnn_param_loader.sv
// bnn_param_loader: load/verify sequencer for the daisy-chained neuron parameter shift registers
module bnn_param_loader
    import bnn_param_loader_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       start_load,
    input  logic       start_verify,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    output logic       in_ready,
    output logic       chain_setup,
    output logic       chain_param,
    input  logic       chain_return,
    output logic       busy,
    output logic       done,
    output logic       params_valid,
    output logic       mismatch
);
    state_e           state_q;
    logic [CNT_W-1:0] bit_cnt_q;
    logic             done_q, pv_q, mm_q;
    logic             setup, msb, start;

    assign busy         = state_q != IDLE;
    assign start        = state_q == IDLE && (start_load || start_verify);
    assign chain_setup  = setup;
    assign chain_param  = setup && (state_q == VERIFY ? chain_return : msb);
    assign done         = done_q;
    assign params_valid = pv_q;
    assign mismatch     = mm_q;

    bnn_param_serializer u_ser (
        .clk      (clk),
        .reset    (reset),
        .active   (busy),
        .clear    (start),
        .bit_cnt  (bit_cnt_q),
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .setup    (setup),
        .msb      (msb)
    );

    // Pass sequencing, bit counting, verify compare and status flags
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            bit_cnt_q <= '0;
            done_q    <= 1'b0;
            pv_q      <= 1'b0;
            mm_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (state_q == IDLE) begin
                if (start) begin
                    state_q   <= start_load ? LOAD : VERIFY;
                    bit_cnt_q <= '0;
                    pv_q      <= 1'b0;
                    mm_q      <= start_load ? mm_q : 1'b0;
                end
            end else if (bit_cnt_q == CNT_W'(CHAIN_BITS)) begin
                state_q <= IDLE;
                done_q  <= 1'b1;
                pv_q    <= 1'b1;
            end else if (setup) begin
                bit_cnt_q <= bit_cnt_q + CNT_W'(1);
                mm_q      <= mm_q || (state_q == VERIFY && chain_return != msb);
            end
        end
    end
endmodule

// File: tb/tb_bnn_param_loader.sv
// tb_bnn_param_loader: directed load/verify passes against a behavioural neuron chain with a scoreboard
module tb_bnn_param_loader;
    import bnn_param_loader_pkg::*;

    localparam int NB = INPUTS + BIAS_BITS;

    typedef struct {
        logic [CHAIN_BITS-1:0] chain;
        logic                  mm;
    } exp_t;

    logic                  clk = 1'b0;
    logic                  reset, start_load, start_verify, in_valid;
    logic [7:0]            in_data;
    logic                  in_ready, chain_setup, chain_param, chain_return;
    logic                  busy, done, params_valid, mismatch;
    logic [CHAIN_BITS-1:0] chain = '0;
    logic [CHAIN_BITS-1:0] loaded = '0;
    logic                  mm_model = 1'b0;
    int                    checks = 0, errors = 0, viol = 0;
    exp_t                  sb[$];

    always #5 clk = ~clk;

    bnn_param_loader dut (
        .clk          (clk),
        .reset        (reset),
        .start_load   (start_load),
        .start_verify (start_verify),
        .in_data      (in_data),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .chain_setup  (chain_setup),
        .chain_param  (chain_param),
        .chain_return (chain_return),
        .busy         (busy),
        .done         (done),
        .params_valid (params_valid),
        .mismatch     (mismatch)
    );

    // Neuron chain: each neuron holds bias then weights; the oldest shifted bit sits at the top
    assign chain_return = chain[CHAIN_BITS-1];
    always @(posedge clk) if (chain_setup) chain <= {chain[CHAIN_BITS-2:0], chain_param};

    // Interface rules that must hold on every cycle
    always @(negedge clk)
        if ((!chain_setup && chain_param) || (chain_setup && in_ready) || (chain_setup && !busy)) viol++;

    function automatic logic [NEURONS-1:0] axons(input logic [CHAIN_BITS-1:0] c, input logic [INPUTS-1:0] x);
        logic [NEURONS-1:0] a;
        for (int n = 0; n < NEURONS; n++)
            a[n] = $countones(c[n*NB +: INPUTS] & x) > int'(c[n*NB+INPUTS +: BIAS_BITS]);
        return a;
    endfunction

    task automatic chk(input string tag, input logic [CHAIN_BITS-1:0] obs, input logic [CHAIN_BITS-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic run_pass(input string tag, input bit ld, input bit vf, input logic [CHAIN_BITS-1:0] s,
                            input bit throttle, input int stop_after, output int res);
        exp_t e;
        int   idx, cyc, first, shifts;
        if (stop_after == 0) begin
            if (ld) begin
                e.chain = s;
                e.mm    = mm_model;
                loaded  = s;
            end else begin
                e.chain  = loaded;
                e.mm     = s != loaded;
                mm_model = e.mm;
            end
            sb.push_back(e);
        end
        start_load   = ld;
        start_verify = vf;
        @(negedge clk);
        start_load   = 1'b0;
        start_verify = 1'b0;
        idx = 0; cyc = 0; first = -1; shifts = 0; res = -1;
        while (!done && cyc < 3000) begin
            if (stop_after > 0 && shifts == stop_after) break;
            start_verify = stop_after > 0 && shifts == 20;
            start_load   = stop_after > 0 && shifts == 25;
            in_valid     = throttle ? (cyc % 3 == 0) : 1'b1;
            in_data      = 8'h00;
            if (idx < NBYTES) in_data = s[CHAIN_BITS-1-8*idx -: 8];
            if (in_valid && in_ready) begin
                if (first < 0) first = cyc;
                idx++;
            end
            if (chain_setup) shifts++;
            @(negedge clk);
            cyc++;
        end
        in_valid     = 1'b0;
        start_load   = 1'b0;
        start_verify = 1'b0;
        if (stop_after > 0) begin
            res = shifts;
        end else begin
            chk({tag, "_done"}, done, 1);
            if (done) res = cyc - 1 - first;
            e = sb.pop_front();
            chk({tag, "_chain"}, chain, e.chain);
            chk({tag, "_mismatch"}, mismatch, e.mm);
            chk({tag, "_pvalid"}, params_valid, 1);
            chk({tag, "_busy"}, busy, 0);
            @(negedge clk);
            chk({tag, "_done_pulse"}, done, 0);
        end
    endtask

    initial begin
        logic [CHAIN_BITS-1:0] p, q, flip, p2;
        int                    r;
        reset = 1'b1; start_load = 1'b0; start_verify = 1'b0; in_valid = 1'b0; in_data = 8'h00;
        repeat (3) @(negedge clk);
        chk("reset_outs", {in_ready, chain_setup, busy, done, params_valid, mismatch}, 0);
        reset = 1'b0;
        @(negedge clk);
        chk("idle_outs", {in_ready, chain_setup, busy, done, params_valid, mismatch}, 0);

        run_pass("t1_ones", 1, 1, '1, 0, 0, r);
        chk("t1_latency", r, 99);

        p2 = {NEURONS{3'd2, 8'h0F}};
        run_pass("t2_load", 1, 0, p2, 0, 0, r);
        chk("t2_axon_07", axons(chain, 8'h07), {NEURONS{1'b1}});
        chk("t2_axon_03", axons(chain, 8'h03), 0);

        p = CHAIN_BITS'({$urandom(), $urandom(), $urandom()});
        run_pass("t3_load", 1, 0, p, 0, 0, r);
        run_pass("t3_verify", 0, 1, p, 0, 0, r);

        flip = p;
        flip[CHAIN_BITS-1-8*5-7+3] = ~flip[CHAIN_BITS-1-8*5-7+3];
        run_pass("t4_verify_bad", 0, 1, flip, 0, 0, r);
        run_pass("t4_verify_good", 0, 1, p, 0, 0, r);
        run_pass("t4_verify_bad2", 0, 1, flip, 0, 0, r);

        q = CHAIN_BITS'({$urandom(), $urandom(), $urandom()});
        run_pass("t5_throttled", 1, 0, q, 1, 0, r);

        run_pass("t6_abort", 1, 0, p, 0, 40, r);
        chk("t6_shifts", r, 40);
        chk("t6_busy_before_reset", busy, 1);
        chk("t6_mismatch_kept", mismatch, 1);
        chk("t6_partial_chain", chain[39:0], p[CHAIN_BITS-1 -: 40]);
        reset = 1'b1;
        @(negedge clk);
        chk("t6_after_reset", {busy, chain_setup, params_valid, in_ready, done, mismatch}, 0);
        reset = 1'b0;
        mm_model = 1'b0;
        @(negedge clk);

        run_pass("t6_reload", 1, 0, q, 0, 0, r);
        run_pass("t6_reverify", 0, 1, q, 0, 0, r);

        chk("protocol_violations", viol, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
